mem_stage_access: RTL

- Consumer of the EX/MEM pipeline register outputs: executes the M-stage data access for the instruction currently held in EX/MEM.
- Generates byte enables and lane-replicated write data, and detects address-alignment exceptions.
- Runs a req/ack handshake to the data bus, and extracts and sign/zero-extends load data.
- Drives the stall that holds EX/MEM (its `en` input) while a bus transaction is outstanding.

---
 rtl/mem_stage_access_pkg.sv | 59 +++++
 rtl/mem_stage_access_load_extend.sv | 40 ++++
 rtl/mem_stage_access.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared constants for the M-stage data access unit.
// Access types, exception codes, FSM states and lane helpers.
package mem_stage_access_pkg;

    localparam logic [3:0] DT_WORD  = 4'd0;
    localparam logic [3:0] DT_HALF  = 4'd1;
    localparam logic [3:0] DT_HALFU = 4'd2;
    localparam logic [3:0] DT_BYTE  = 4'd3;
    localparam logic [3:0] DT_BYTEU = 4'd4;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic isHalfType(input logic [3:0] dt);
        return (dt == DT_HALF) || (dt == DT_HALFU);
    endfunction

    function automatic logic isByteType(input logic [3:0] dt);
        return (dt == DT_BYTE) || (dt == DT_BYTEU);
    endfunction

    // Byte enables for an access of type dt at byte offset lo.
    function automatic logic [3:0] laneBe(
        input logic [3:0] dt,
        input logic [1:0] lo
    );
        logic [3:0] be;
        be = 4'b1111;
        if (isHalfType(dt)) begin
            be = lo[1] ? 4'b1100 : 4'b0011;
        end else if (isByteType(dt)) begin
            be = 4'b0001 << lo;
        end
        return be;
    endfunction

    // Right-aligned store data replicated across all lanes.
    function automatic logic [31:0] laneData(
        input logic [3:0]  dt,
        input logic [31:0] wd
    );
        logic [31:0] d;
        d = wd;
        if (isHalfType(dt)) begin
            d = {2{wd[15:0]}};
        end else if (isByteType(dt)) begin
            d = {4{wd[7:0]}};
        end
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_access_load_extend.sv
// Load lane select and sign/zero extension.
// Pure combinational; shared with the WB stage.
module load_extend
    import mem_stage_access_pkg::*;
(
    input  logic [1:0]  addrLo,
    input  logic [3:0]  dataType,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Pick the addressed byte and halfword out of the bus word.
    always_comb begin
        laneByte = rdata[7:0];
        unique case (addrLo)
            2'd0: laneByte = rdata[7:0];
            2'd1: laneByte = rdata[15:8];
            2'd2: laneByte = rdata[23:16];
            2'd3: laneByte = rdata[31:24];
            default: laneByte = rdata[7:0];
        endcase
        laneHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane; unknown types read as a full word.
    always_comb begin
        result = rdata;
        unique case (dataType)
            DT_HALF:  result = {{16{laneHalf[15]}}, laneHalf};
            DT_HALFU: result = {16'd0, laneHalf};
            DT_BYTE:  result = {{24{laneByte[7]}}, laneByte};
            DT_BYTEU: result = {24'd0, laneByte};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// M-stage data access: alignment check, bus req/ack, load extend.
// Optional bus timeout when BUS_TIMEOUT_EN is defined.
module mem_stage_access #(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [4:0] EXC_DBE = mem_stage_access_pkg::EXC_DBE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [3:0]  DataTypeM,
    input  logic [31:0] ALUResM,
    input  logic [31:0] WriteDataM,
    input  logic        ExcOccurM,
    input  logic [4:0]  ExcCodeM,
    input  logic        flush,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ReadDataM,
    output logic        done,
    output logic        ExcOccurOut,
    output logic [4:0]  ExcCodeOut
);

    import mem_stage_access_pkg::*;

    state_t      state;
    logic        memOp;
    logic        isHalf;
    logic        isWord;
    logic        mis;
    logic        acc;
    logic        killed;
    logic        tmoFlag;
    logic [1:0]  addrLo;
    logic [3:0]  dtReg;
    logic [31:0] loadVal;

    assign memOp  = MemtoRegM | MemWriteM;
    assign isHalf = isHalfType(DataTypeM);
    assign isWord = !isHalf && !isByteType(DataTypeM);
    assign mis    = memOp
                  & ((isWord & (|ALUResM[1:0]))
                  |  (isHalf & ALUResM[0]));
    assign acc    = memOp & !ExcOccurM & !mis & !flush;

    assign stall = ((state == ST_IDLE) & acc)
                 | (state == ST_BUSY);

    load_extend u_ext (
        .addrLo   (addrLo),
        .dataType (dtReg),
        .rdata    (bus_rdata),
        .result   (loadVal)
    );

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmoCnt;
`else
    assign tmoFlag = 1'b0;
`endif

    // Access FSM: latch on accept, hold until ack, pulse done once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            ReadDataM <= 32'd0;
            done      <= 1'b0;
            killed    <= 1'b0;
            addrLo    <= 2'd0;
            dtReg     <= DT_WORD;
`ifdef BUS_TIMEOUT_EN
            tmoCnt    <= 8'd0;
            tmoFlag   <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (acc) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUResM[31:2], 2'b00};
                        bus_be    <= laneBe(DataTypeM, ALUResM[1:0]);
                        bus_wdata <= laneData(DataTypeM, WriteDataM);
                        addrLo    <= ALUResM[1:0];
                        dtReg     <= DataTypeM;
                        killed    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                        tmoCnt    <= 8'd0;
`endif
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        killed <= 1'b1;
                    end
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        ReadDataM <= loadVal;
                        done      <= !(killed | flush);
                        state     <= ST_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmoCnt == TMO_LAST) begin
                        bus_req <= 1'b0;
                        done    <= !(killed | flush);
                        tmoFlag <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        tmoCnt <= tmoCnt + 8'd1;
                    end
`endif
                end
                ST_RESP: begin
                    done  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                    tmoFlag <= 1'b0;
`endif
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Exception merge: upstream, then alignment, then bus timeout.
    always_comb begin
        ExcOccurOut = 1'b0;
        ExcCodeOut  = 5'd0;
        if (ExcOccurM) begin
            ExcOccurOut = 1'b1;
            ExcCodeOut  = ExcCodeM;
        end else if (mis) begin
            ExcOccurOut = 1'b1;
            ExcCodeOut  = MemtoRegM ? EXC_ADEL : EXC_ADES;
        end else if (tmoFlag) begin
            ExcOccurOut = 1'b1;
            ExcCodeOut  = EXC_DBE;
        end
    end

endmodule
